// File: rtl/rf_pkg.sv
// Shared constants and types for the register file with write-back scoreboard.
package rf_pkg;

  // Default architectural configuration (RV32I-style integer register file).
  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);

  // Register index type for the default configuration.
  typedef logic [RF_AW-1:0] reg_idx_t;

  // Hard-wired zero register: reads as 0, never written, never busy.
  localparam reg_idx_t ZERO_REG = '0;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on
// write-back or flush, with same-cycle write-back resolving hazards early.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS = RF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          rs1_used,
  input  logic          rs2_used,
  input  logic          we,
  input  logic [AW-1:0] rd,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          flush,
  output logic          stall,
  output logic          issued,
  output logic [AW:0]   pending
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      pending_q;
  logic [AW:0]      pending_d;

  // Per-register decode of the write-back and issue destinations.
  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] set_hit;
  logic [NREGS-1:0] eb;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_hit
      if (gi == 0) begin : g_zero
        // Register 0 can never be outstanding.
        assign wb_hit[gi]  = 1'b0;
        assign set_hit[gi] = 1'b0;
      end else begin : g_nz
        assign wb_hit[gi]  = we && (rd == AW'(gi));
        assign set_hit[gi] = issued && (issue_rd == AW'(gi));
      end
    end
  endgenerate

  // A write-back landing this cycle already satisfies any consumer of it.
  assign eb = busy_q & ~wb_hit;

  // Hazard detection: RAW on used sources, WAW on a real destination.
  always_comb begin
    stall  = issue_valid & ((rs1_used & eb[rs1]) |
                            (rs2_used & eb[rs2]) |
                            ((issue_rd != '0) & eb[issue_rd]));
    issued = issue_valid & ~stall & ~flush;
  end

  // Next busy state: flush clears everything; otherwise clear, then set (newer producer wins).
  always_comb begin
    busy_d = '0;
    if (!flush) begin
      busy_d = (busy_q & ~wb_hit) | set_hit;
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector, so pending tracks busy exactly.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      pending_d = pending_d + (AW+1)'(busy_d[i]);
    end
  end

  // Busy vector and pending count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule : rf_scoreboard

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-back bypass and an integrated
// pending-write scoreboard for decode-stage hazard stalls.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int XLEN  = RF_XLEN,
  parameter  int NREGS = RF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] read1,
  output logic [XLEN-1:0] read2,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic            stall,
  output logic            issued,
  output logic [AW:0]     pending
);

  // Flat read view of the storage; entry 0 is the hard-wired zero register.
  logic [XLEN-1:0] rf_view [NREGS];

  assign rf_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [XLEN-1:0] reg_q;
      logic [XLEN-1:0] reg_d;

      // Load write-back data when this register is the destination.
      always_comb begin
        reg_d = reg_q;
        if (we && (rd == AW'(gi))) begin
          reg_d = wd;
        end
      end

      // Register storage; reset clears contents immediately.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rf_view[gi] = reg_q;
    end
  endgenerate

  // Read port 1: zero register, then same-cycle bypass, then array.
  always_comb begin
    read1 = '0;
    if (rs1 != '0) begin
      if (we && (rd == rs1)) begin
        read1 = wd;
      end else begin
        read1 = rf_view[rs1];
      end
    end
  end

  // Read port 2: zero register, then same-cycle bypass, then array.
  always_comb begin
    read2 = '0;
    if (rs2 != '0) begin
      if (we && (rd == rs2)) begin
        read2 = wd;
      end else begin
        read2 = rf_view[rs2];
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .we          (we),
    .rd          (rd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .stall       (stall),
    .issued      (issued),
    .pending     (pending)
  );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb plus hand-written reset sequences.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, issue_rd = '0;
  logic        rs1_used = 1'b0, rs2_used = 1'b0, we = 1'b0;
  logic        issue_valid = 1'b0, flush = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] read1, read2;
  logic        stall, issued;
  logic [5:0]  pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .read1(read1), .read2(read2), .we(we), .rd(rd), .wd(wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .stall(stall), .issued(issued), .pending(pending)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] e_r1, e_r2;
    logic        e_stall, e_issued;
    int          e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [4:0] a1, logic [4:0] a2, logic u1, logic u2,
                              logic w, logic [4:0] d, logic [31:0] dat,
                              logic iv, logic [4:0] ird, logic fl,
                              logic [31:0] r1, logic [31:0] r2, logic st, logic is, int p);
    vec_t v;
    v.rs1 = a1; v.rs2 = a2; v.u1 = u1; v.u2 = u2; v.we = w; v.rd = d; v.wd = dat;
    v.iv = iv; v.ird = ird; v.fl = fl;
    v.e_r1 = r1; v.e_r2 = r2; v.e_stall = st; v.e_issued = is; v.e_pend = p;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; rs1_used = v.u1; rs2_used = v.u2;
    we = v.we; rd = v.rd; wd = v.wd;
    issue_valid = v.iv; issue_rd = v.ird; flush = v.fl;
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rs1_used = 0; rs2_used = 0; we = 0; rd = '0; wd = '0;
    issue_valid = 0; issue_rd = '0; flush = 0;
  endtask

  initial begin
    //            rs1 rs2 u1 u2 we rd wd            iv ird fl  r1            r2  st is p
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0, 0, 0, 0)); // 0 reset state
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 32'hAAAAAAAA,  0, 0, 0, 32'hAAAAAAAA,  32'h0, 0, 0, 0)); // 1 bypass
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'hAAAAAAAA,  32'hAAAAAAAA, 0, 0, 0)); // 2 from array
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF,  0, 0, 0, 32'h0,         32'h0, 0, 0, 0)); // 3 write r0
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0, 0, 1, 0)); // 4 r0 reads 0, issue rd0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0, 0, 0, 0)); // 5 pending stays 0
    vecs.push_back(mk(1, 2, 1, 1, 0, 0, 32'h0,         1, 5, 0, 32'hAAAAAAAA,  32'h0, 0, 1, 0)); // 6 issue rd5
    vecs.push_back(mk(5, 0, 1, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0, 1, 0, 1)); // 7 RAW stall
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0, 0, 1, 1)); // 8 unused operand
    vecs.push_back(mk(5, 0, 1, 0, 1, 5, 32'h12345678,  1, 0, 0, 32'h12345678,  32'h0, 0, 1, 1)); // 9 wb resolves
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h12345678,  32'h0, 0, 0, 0)); // 10 cleared
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         1, 7, 0, 32'h0,         32'h0, 0, 1, 0)); // 11 issue rd7
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0, 0, 0, 1)); // 12
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 32'h00000077,  1, 7, 0, 32'h0,         32'h0, 0, 1, 1)); // 13 set+clear
    vecs.push_back(mk(7, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h00000077,  32'h0, 0, 0, 1)); // 14 set won
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         1, 7, 0, 32'h0,         32'h0, 1, 0, 1)); // 15 WAW stall
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 32'h00000070,  0, 0, 0, 32'h0,         32'h0, 0, 0, 1)); // 16 clear r7
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         1, 3, 0, 32'h0,         32'h0, 0, 1, 0)); // 17 issue rd3
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         1, 4, 0, 32'h0,         32'h0, 0, 1, 1)); // 18 issue rd4
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         1, 9, 0, 32'h0,         32'h0, 0, 1, 2)); // 19 issue rd9
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0, 0, 0, 3)); // 20 three busy
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 32'h00000022,  1, 10, 1, 32'h0,        32'h0, 0, 0, 3)); // 21 flush drops issue
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 32'h0,         1, 10, 0, 32'h00000022, 32'h0, 0, 1, 0)); // 22 busy10 clear, write kept
    vecs.push_back(mk(3, 9, 1, 1, 0, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0, 0, 1, 1)); // 23 busy3/9 flushed
    vecs.push_back(mk(0, 10, 0, 1, 0, 0, 32'h0,        1, 0, 0, 32'h0,         32'h0, 1, 0, 1)); // 24 busy10 set

    // Reset values while reset is held.
    #1;
    check("rst_read1", -1, read1, 32'h0);
    check("rst_pending", -1, 32'(pending), 32'd0);
    check("rst_stall", -1, 32'(stall), 32'd0);
    check("rst_issued", -1, 32'(issued), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check("read1", i, read1, vecs[i].e_r1);
      check("read2", i, read2, vecs[i].e_r2);
      check("stall", i, 32'(stall), 32'(vecs[i].e_stall));
      check("issued", i, 32'(issued), 32'(vecs[i].e_issued));
      check("pending", i, 32'(pending), 32'(vecs[i].e_pend));
      $display("vec %0d: r1=%h r2=%h stall=%0d issued=%0d pending=%0d", i, read1, read2, stall, issued, pending);
    end

    // Async reset pulse between edges: contents and busy state vanish immediately.
    @(negedge clk);
    idle();
    rs1 = 5'd1; rs2 = 5'd5; rs2_used = 1'b0;
    #1;
    check("pre_rst_read1", 100, read1, 32'hAAAAAAAA);
    check("pre_rst_read2", 100, read2, 32'h12345678);
    check("pre_rst_pending", 100, 32'(pending), 32'd1);
    issue_valid = 1'b1; rs2 = 5'd10; rs2_used = 1'b1;
    #1;
    check("pre_rst_stall", 100, 32'(stall), 32'd1);
    rs2 = 5'd5; rs2_used = 1'b0; issue_valid = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("post_rst_read1", 101, read1, 32'h0);
    check("post_rst_read2", 101, read2, 32'h0);
    check("post_rst_pending", 101, 32'(pending), 32'd0);
    issue_valid = 1'b1; rs2 = 5'd10; rs2_used = 1'b1;
    #1;
    check("post_rst_stall", 101, 32'(stall), 32'd0);
    check("post_rst_issued", 101, 32'(issued), 32'd1);
    $display("reset pulse: r1=%h r2=%h stall=%0d pending=%0d", read1, read2, stall, pending);
    @(negedge clk);
    idle();
    #1;
    check("post_rst_rd0_issue_pending", 102, 32'(pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_sb
